flag_branch_seq: RTL and testbench
==================================

FLAG_BRANCH_SEQ -- requirements
Module: flag_branch_seq

Interface
REQ-001 Parameter ADDR_WIDTH, default 8: width of the program counter and branch target.
REQ-002 Parameter STACK_DEPTH, default 4: number of return-stack entries; SHALL be a power of two, 2..16.
REQ-003 clk  in  1  single clock; all state updates on its rising edge.
REQ-004 rst  in  1  reset; synchronous, active-low (rst=0 at a rising clk edge resets the block).
REQ-005 pc_en  in  1  sequential advance request: pc <= pc+1 when honoured.
REQ-006 br_valid  in  1  branch request valid.
REQ-007 br_ready  out  1  branch request can be accepted this cycle.
REQ-008 br_cond  in  3  condition code.
REQ-009 br_target  in  ADDR_WIDTH  jump destination.
REQ-010 br_call  in  1  treat the branch as a call (push return address).
REQ-011 br_ret  in  1  treat the branch as a return (pop destination).
REQ-012 C, N, P, Z  in  1 each  flags from the flag register: carry, negative, even parity, zero.
REQ-013 pc  out  ADDR_WIDTH  current program counter, registered.
REQ-014 taken  out  1  one-cycle pulse: the branch just resolved was taken.
REQ-015 busy  out  1  a branch is in flight (state is not IDLE).
REQ-016 stk_ovf, stk_unf  out  1 each  sticky return-stack overflow and underflow flags.

Function
REQ-017 FSM states SHALL be IDLE, EVAL and UPDATE: IDLE->EVAL on accept; EVAL->UPDATE unconditionally; UPDATE->IDLE unconditionally.
REQ-018 br_ready SHALL be 1 only in IDLE; accept = br_valid & br_ready; br_cond, br_target, br_call and br_ret SHALL be captured on accept.
REQ-019 In EVAL the block SHALL sample C/N/P/Z and register take = cond(br_cond): 000 always; 001 Z; 010 !Z; 011 C; 100 !C; 101 N; 110 P; 111 !P.
REQ-020 In UPDATE, pc SHALL become:
- the stack top, if a return is taken;
- br_target, if any other branch is taken;
- pc+1, if the branch is not taken.
REQ-021 In UPDATE, taken SHALL pulse high for exactly one cycle when the branch is taken.
REQ-022 Latency: for a branch accepted at edge T, the new pc SHALL be visible after edge T+2; the next accept is possible at edge T+3.
REQ-023 In IDLE with pc_en=1 and no accept, pc SHALL increment by 1.
REQ-024 pc increments SHALL wrap from 2^ADDR_WIDTH-1 to 0, silently.
REQ-025 When pc_en and accept occur in the same IDLE cycle, the branch SHALL win and pc SHALL hold.
REQ-026 pc_en SHALL be ignored in EVAL and UPDATE.
REQ-027 br_call and br_ret both high SHALL be treated as br_ret.
REQ-028 busy SHALL equal (state != IDLE).

Reset
REQ-029 On reset: state=IDLE, pc=0, taken=0, busy=0, br_ready=1, stack pointer=0 (empty), stk_ovf=0, stk_unf=0.
REQ-030 Reset SHALL abort an in-flight branch (EVAL or UPDATE) with no pc change and no taken pulse.
REQ-031 Reset SHALL take priority over all other inputs.

Configuration
REQ-032 Macro FBS_CALL_STACK_EN defined: the return stack SHALL be implemented with STACK_DEPTH entries.
REQ-033 Taken call: SHALL push pc+1 (wrapped).
REQ-034 Taken call when full: SHALL jump without pushing and set stk_ovf.
REQ-035 Taken return when empty: SHALL load pc+1 instead of the stack top and set stk_unf.
REQ-036 Not-taken call/return: SHALL leave the stack unchanged.
REQ-037 stk_ovf and stk_unf SHALL clear only on reset.
REQ-038 Macro undefined: SHALL build no stack; br_call and br_ret SHALL be ignored (the branch behaves as a plain jump to br_target); stk_ovf and stk_unf SHALL be tied to 0.

Verification
REQ-039 Reset, then pc_en=1 for 5 cycles -> pc=5; ADDR_WIDTH=8 starting from pc=255 with pc_en=1 -> pc=0.
REQ-040 pc=10, Z=1, br_cond=001, br_target=0x40 -> br_ready low for 2 cycles, taken pulses, pc=0x40 after edge T+2; repeat with Z=0 -> pc=11, no taken pulse.
REQ-041 br_valid and pc_en together at pc=3, br_cond=000, br_target=0x20 -> pc holds 3 at edge T, becomes 0x20 after edge T+2.
REQ-042 (FBS_CALL_STACK_EN) call from pc=7 to 0x30, then return with cond 000 -> pc=8; 5 nested calls at depth 4 -> stk_ovf=1; return on an empty stack from pc=9 -> pc=10, stk_unf=1.
REQ-043 rst=0 asserted while in EVAL -> next cycle state IDLE, pc=0, taken=0, busy=0, sticky flags 0.

Source files
------------

// File: rtl/flag_branch_seq.sv
// Flag-conditioned branch sequencer: owns the program counter and resolves one
// branch per three cycles. Optional return stack is built when FBS_CALL_STACK_EN is defined.
module flag_branch_seq #(
    parameter int ADDR_WIDTH  = 8,
    parameter int STACK_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  pc_en,
    input  logic                  br_valid,
    output logic                  br_ready,
    input  logic [2:0]            br_cond,
    input  logic [ADDR_WIDTH-1:0] br_target,
    input  logic                  br_call,
    input  logic                  br_ret,
    input  logic                  C,
    input  logic                  N,
    input  logic                  P,
    input  logic                  Z,
    output logic [ADDR_WIDTH-1:0] pc,
    output logic                  taken,
    output logic                  busy,
    output logic                  stk_ovf,
    output logic                  stk_unf
);

    typedef enum logic [1:0] {IDLE, EVAL, UPDATE} state_t;

    state_t                  state_reg, state_next;
    logic [2:0]              cond_reg;
    logic [ADDR_WIDTH-1:0]   target_reg;
    logic                    call_reg, ret_reg, take_reg;
    logic                    accept, cond_true;
    logic [ADDR_WIDTH-1:0]   pc_inc, dest;

    assign br_ready = (state_reg == IDLE);
    assign busy     = (state_reg != IDLE);
    assign accept   = br_valid & br_ready;
    assign pc_inc   = pc + 1'b1;

    always_comb begin
        cond_true = 1'b0;
        case (cond_reg)
            3'b000: cond_true = 1'b1;
            3'b001: cond_true = Z;
            3'b010: cond_true = ~Z;
            3'b011: cond_true = C;
            3'b100: cond_true = ~C;
            3'b101: cond_true = N;
            3'b110: cond_true = P;
            3'b111: cond_true = ~P;
            default: cond_true = 1'b0;
        endcase
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (accept) state_next = EVAL;
            EVAL:    state_next = UPDATE;
            UPDATE:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) state_reg <= IDLE;
        else      state_reg <= state_next;
    end

`ifdef FBS_CALL_STACK_EN
    localparam int IW  = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam int SPW = IW + 1;

    logic [SPW-1:0]        sp_reg;
    logic [ADDR_WIDTH-1:0] stack_mem [STACK_DEPTH];
    logic [ADDR_WIDTH-1:0] top_reg;
    logic                  ovf_reg, unf_reg;
    logic                  stack_full, stack_empty, do_call, do_ret, push;

    assign stack_full  = (sp_reg == SPW'(STACK_DEPTH));
    assign stack_empty = (sp_reg == '0);
    // A return wins over a call when both are flagged.
    assign do_call = (state_reg == UPDATE) && take_reg && call_reg && !ret_reg;
    assign do_ret  = (state_reg == UPDATE) && take_reg && ret_reg;
    assign push    = rst && do_call && !stack_full;
    assign dest    = ret_reg ? (stack_empty ? pc_inc : top_reg) : target_reg;

    always_ff @(posedge clk) begin
        if (push) stack_mem[sp_reg[IW-1:0]] <= pc_inc;
    end

    // Stack top is read during EVAL so it is ready for the UPDATE cycle.
    always_ff @(posedge clk) begin
        if (state_reg == EVAL) top_reg <= stack_mem[IW'(sp_reg - 1'b1)];
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            sp_reg  <= '0;
            ovf_reg <= 1'b0;
            unf_reg <= 1'b0;
        end else begin
            if (do_call) begin
                if (stack_full) ovf_reg <= 1'b1;
                else            sp_reg  <= sp_reg + 1'b1;
            end
            if (do_ret) begin
                if (stack_empty) unf_reg <= 1'b1;
                else             sp_reg  <= sp_reg - 1'b1;
            end
        end
    end

    assign stk_ovf = ovf_reg;
    assign stk_unf = unf_reg;
`else
    logic unused_stack_inputs;
    assign unused_stack_inputs = call_reg ^ ret_reg;
    assign dest    = target_reg;
    assign stk_ovf = 1'b0;
    assign stk_unf = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            pc         <= '0;
            taken      <= 1'b0;
            take_reg   <= 1'b0;
            cond_reg   <= '0;
            target_reg <= '0;
            call_reg   <= 1'b0;
            ret_reg    <= 1'b0;
        end else begin
            taken <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        cond_reg   <= br_cond;
                        target_reg <= br_target;
                        call_reg   <= br_call;
                        ret_reg    <= br_ret;
                    end else if (pc_en) begin
                        pc <= pc_inc;
                    end
                end
                EVAL: take_reg <= cond_true;
                UPDATE: begin
                    if (take_reg) begin
                        taken <= 1'b1;
                        pc    <= dest;
                    end else begin
                        pc <= pc_inc;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_flag_branch_seq.sv
// Directed bench for flag_branch_seq; stack scenarios run when FBS_CALL_STACK_EN is defined.
module tb_flag_branch_seq;

    logic       clk = 1'b0;
    logic       rst, pc_en, br_valid, br_call, br_ret, C, N, P, Z;
    logic [2:0] br_cond;
    logic [7:0] br_target, pc;
    logic       br_ready, taken, busy, stk_ovf, stk_unf;

    int n_total = 0;
    int n_pass  = 0;
    logic [7:0] model_pc;

    flag_branch_seq #(.ADDR_WIDTH(8), .STACK_DEPTH(4)) dut (
        .clk(clk), .rst(rst), .pc_en(pc_en), .br_valid(br_valid), .br_ready(br_ready),
        .br_cond(br_cond), .br_target(br_target), .br_call(br_call), .br_ret(br_ret),
        .C(C), .N(N), .P(P), .Z(Z), .pc(pc), .taken(taken), .busy(busy),
        .stk_ovf(stk_ovf), .stk_unf(stk_unf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic step(input int n);
        pc_en = 1'b1;
        for (int i = 0; i < n; i++) begin
            tick();
            model_pc = model_pc + 8'd1;
        end
        pc_en = 1'b0;
        check("step_pc", pc, model_pc);
        $display("step n=%0d pc=%0h", n, pc);
    endtask

    task automatic branch(input logic [2:0] cond, input logic [7:0] tgt, input logic call,
                          input logic ret, input logic en, input logic [7:0] exp_pc,
                          input logic exp_tk);
        br_valid = 1'b1; br_cond = cond; br_target = tgt;
        br_call = call; br_ret = ret; pc_en = en;
        check("ready_idle", br_ready, 1);
        tick();                                  // edge T: accept
        br_valid = 1'b0;
        check("hold_T", pc, model_pc);
        check("ready_eval", br_ready, 0);
        check("busy_eval", busy, 1);
        tick();                                  // edge T+1
        check("ready_upd", br_ready, 0);
        check("pc_upd", pc, model_pc);
        tick();                                  // edge T+2
        check("pc_new", pc, exp_pc);
        check("taken", taken, exp_tk);
        check("busy_done", busy, 0);
        pc_en = 1'b0;
        model_pc = exp_pc;
        tick();
        check("taken_drop", taken, 0);
        check("pc_stable", pc, model_pc);
        $display("branch cond=%b tgt=%0h call=%b ret=%b -> pc=%0h taken_exp=%b",
                 cond, tgt, call, ret, exp_pc, exp_tk);
    endtask

    initial begin
        rst = 1'b0; pc_en = 1'b0; br_valid = 1'b0; br_call = 1'b0; br_ret = 1'b0;
        br_cond = 3'b000; br_target = 8'h00; C = 1'b0; N = 1'b0; P = 1'b0; Z = 1'b0;
        model_pc = 8'h00;
        tick(); tick();
        rst = 1'b1;
        check("rst_pc", pc, 0);
        check("rst_busy", busy, 0);
        check("rst_ready", br_ready, 1);
        check("rst_taken", taken, 0);
        check("rst_ovf", stk_ovf, 0);
        check("rst_unf", stk_unf, 0);

        step(5);                                            // pc = 5
        branch(3'b000, 8'd10, 0, 0, 0, 8'd10, 1);
        Z = 1'b1;
        branch(3'b001, 8'h40, 0, 0, 0, 8'h40, 1);
        branch(3'b000, 8'd10, 0, 0, 0, 8'd10, 1);
        Z = 1'b0;
        branch(3'b001, 8'h40, 0, 0, 0, 8'd11, 0);
        branch(3'b000, 8'd3, 0, 0, 0, 8'd3, 1);
        branch(3'b000, 8'h20, 0, 0, 1, 8'h20, 1);           // pc_en with accept
        branch(3'b000, 8'hFF, 0, 0, 0, 8'hFF, 1);
        step(1);                                            // wraps to 0

        Z = 1'b1; C = 1'b1; N = 1'b1; P = 1'b0;
        branch(3'b010, 8'h50, 0, 0, 0, 8'h01, 0);
        branch(3'b011, 8'h50, 0, 0, 0, 8'h50, 1);
        branch(3'b100, 8'h60, 0, 0, 0, 8'h51, 0);
        branch(3'b101, 8'h60, 0, 0, 0, 8'h60, 1);
        branch(3'b110, 8'h70, 0, 0, 0, 8'h61, 0);
        branch(3'b111, 8'h70, 0, 0, 0, 8'h70, 1);
        C = 1'b0;
        branch(3'b100, 8'h80, 0, 0, 0, 8'h80, 1);

`ifdef FBS_CALL_STACK_EN
        branch(3'b000, 8'd7, 0, 0, 0, 8'd7, 1);
        branch(3'b000, 8'h30, 1, 0, 0, 8'h30, 1);           // call, push 8
        branch(3'b000, 8'hAA, 0, 1, 0, 8'd8, 1);            // return
        branch(3'b000, 8'h10, 1, 0, 0, 8'h10, 1);           // push 9
        branch(3'b000, 8'h20, 1, 0, 0, 8'h20, 1);           // push 0x11
        branch(3'b000, 8'h30, 1, 0, 0, 8'h30, 1);           // push 0x21
        branch(3'b000, 8'h40, 1, 0, 0, 8'h40, 1);           // push 0x31, full
        check("ovf_before", stk_ovf, 0);
        branch(3'b000, 8'h50, 1, 0, 0, 8'h50, 1);           // overflow
        check("ovf_set", stk_ovf, 1);
        Z = 1'b0;
        branch(3'b001, 8'hEE, 0, 1, 0, 8'h51, 0);           // not-taken return
        branch(3'b000, 8'hEE, 0, 1, 0, 8'h31, 1);
        branch(3'b000, 8'hEE, 1, 1, 0, 8'h21, 1);           // both high acts as return
        branch(3'b000, 8'hEE, 0, 1, 0, 8'h11, 1);
        branch(3'b000, 8'hEE, 0, 1, 0, 8'd9, 1);
        check("unf_before", stk_unf, 0);
        branch(3'b000, 8'hEE, 0, 1, 0, 8'd10, 1);           // empty return
        check("unf_set", stk_unf, 1);
        check("ovf_sticky", stk_ovf, 1);
`else
        branch(3'b000, 8'h30, 1, 0, 0, 8'h30, 1);           // call acts as jump
        branch(3'b000, 8'h55, 0, 1, 0, 8'h55, 1);           // return acts as jump
        check("ovf_tied", stk_ovf, 0);
        check("unf_tied", stk_unf, 0);
`endif

        // reset while in EVAL
        br_valid = 1'b1; br_cond = 3'b000; br_target = 8'h77;
        tick();
        br_valid = 1'b0;
        check("eval_busy", busy, 1);
        rst = 1'b0;
        tick();
        check("abort_busy", busy, 0);
        check("abort_ready", br_ready, 1);
        check("abort_pc", pc, 0);
        check("abort_taken", taken, 0);
        check("abort_ovf", stk_ovf, 0);
        check("abort_unf", stk_unf, 0);
        rst = 1'b1;
        tick(); tick();
        check("post_abort_pc", pc, 0);
        check("post_abort_taken", taken, 0);
        $display("reset abort pc=%0h", pc);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
